// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: one round per clock, round keys fetched by index
// from an external combinational key store.
module aes_inv_round_ctrl #(
  parameter int unsigned NR    = 10,
  parameter int unsigned RKI_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     data_in,
  output logic [RKI_W-1:0] rk_idx,
  input  logic [127:0]     rk_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     data_out,
  output logic             busy,
  output logic [RKI_W-1:0] round
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} fsm_e;

  localparam logic [RKI_W-1:0] LastIdx = RKI_W'(NR);
  localparam logic [RKI_W-1:0] One     = RKI_W'(1);

  fsm_e             fsm_q;
  logic [127:0]     state_q;
  logic [RKI_W-1:0] round_q;
  logic             out_valid_q, busy_q, in_ready_q;
  logic [127:0]     sub_q, ark, mix;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 as the product of x^2, x^4, ..., x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] y, s;
    y = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      y = gmul(y, s);
    end
    return y;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  // Byte i = row (i % 4), column (i / 4); byte 0 sits in the top bits.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  always_comb begin
    sub_q = inv_sub_bytes(inv_shift_rows(state_q));
    ark   = sub_q ^ rk_in;
    mix   = inv_mix_columns(ark);
  end

  always_comb begin
    rk_idx = '0;
    unique case (fsm_q)
      StIdle:  rk_idx = LastIdx;
      StRound: rk_idx = round_q;
      StFinal: rk_idx = '0;
      StDone:  rk_idx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= data_in ^ rk_in;
            round_q    <= LastIdx - One;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            fsm_q      <= (NR == 1) ? StFinal : StRound;
          end
        end
        StRound: begin
          state_q <= mix;
          if (round_q == One) fsm_q <= StFinal;
          else                round_q <= round_q - One;
        end
        StFinal: begin
          state_q     <= ark;
          round_q     <= '0;
          out_valid_q <= 1'b1;
          fsm_q       <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= StIdle;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = state_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: FIPS-197 C.1 / C.3 decrypts, back-pressure,
// mid-flight reset, rk_idx trace and back-to-back throughput.
module tb_aes_inv_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] Ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Junk = 128'hdeadbeef0123456789abcdeffedcba98;

  // NR=10 instance
  logic         a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [127:0] a_data_in = '0;
  logic         a_in_ready, a_out_valid, a_busy;
  logic [3:0]   a_rk_idx, a_round;
  logic [127:0] a_rk_in, a_data_out;
  // NR=14 instance
  logic         b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [127:0] b_data_in = '0;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [3:0]   b_rk_idx, b_round;
  logic [127:0] b_rk_in, b_data_out;

  logic [127:0] rk10 [0:10];
  logic [127:0] rk14 [0:14];
  logic [31:0]  w [0:59];

  assign a_rk_in = (a_rk_idx <= 4'd10) ? rk10[a_rk_idx] : '0;
  assign b_rk_in = (b_rk_idx <= 4'd14) ? rk14[b_rk_idx] : '0;

  aes_inv_round_ctrl #(.NR(10), .RKI_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in),
    .rk_idx(a_rk_idx), .rk_in(a_rk_in), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .data_out(a_data_out), .busy(a_busy), .round(a_round)
  );

  aes_inv_round_ctrl #(.NR(14), .RKI_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
    .rk_idx(b_rk_idx), .rk_in(b_rk_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_data_out), .busy(b_busy), .round(b_round)
  );

  // Key schedule helpers (forward S-box only, for generating round keys)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = 8'h01;
    for (int k = 0; k < 254; k++) v = mul(v, b);
    if (b == 8'h00) v = 8'h00;
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  task automatic expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_out_valid"}, 128'(a_out_valid), 128'd0);
    check({tag, "_busy"},      128'(a_busy),      128'd0);
    check({tag, "_in_ready"},  128'(a_in_ready),  128'd1);
    check({tag, "_data_out"},  a_data_out,        128'd0);
    check({tag, "_round"},     128'(a_round),     128'd0);
    check({tag, "_rk_idx"},    128'(a_rk_idx),    128'd10);
  endtask

  int n;
  int acc [0:1];
  int nacc;

  initial begin
    expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Reset state
    step(); step();
    rst = 1'b0;
    check_reset_a("reset");
    check("reset_b_rk_idx", 128'(b_rk_idx), 128'd14);

    // C.1 with rk_idx trace; a different block is offered mid-flight and must be ignored
    a_in_valid = 1'b1;
    a_data_in  = Ct1;
    check("c1_idle_rk_idx", 128'(a_rk_idx), 128'd10);
    step();
    a_in_valid = 1'b0;
    a_data_in  = Junk;
    for (int k = 9; k >= 1; k--) begin
      check("c1_rk_idx_round", 128'(a_rk_idx), 128'(k));
      check("c1_out_valid_low", 128'(a_out_valid), 128'd0);
      if (k == 6) begin
        a_in_valid = 1'b1;
        check("ignore_in_ready", 128'(a_in_ready), 128'd0);
      end else begin
        a_in_valid = 1'b0;
      end
      step();
    end
    a_in_valid = 1'b0;
    check("c1_rk_idx_final", 128'(a_rk_idx), 128'd0);
    check("c1_out_valid_final", 128'(a_out_valid), 128'd0);
    step();
    // 11th edge counting the accept edge
    check("c1_latency_out_valid", 128'(a_out_valid), 128'd1);
    check("c1_plaintext", a_data_out, Pt);

    // Back-pressure: 20 cycles stalled in DONE, with an offered block that must wait
    a_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_out_valid", 128'(a_out_valid), 128'd1);
      check("bp_data_out", a_data_out, Pt);
      check("bp_in_ready", 128'(a_in_ready), 128'd0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    check("bp_release_out_valid", 128'(a_out_valid), 128'd0);
    check("bp_release_in_ready", 128'(a_in_ready), 128'd1);
    check("bp_release_busy", 128'(a_busy), 128'd0);

    // C.3 on the NR=14 instance
    b_in_valid = 1'b1;
    b_data_in  = Ct3;
    step();
    b_in_valid = 1'b0;
    b_data_in  = Junk;
    n = 1;
    while (!b_out_valid && n < 40) begin
      step();
      n++;
    end
    check("c3_latency", 128'(n), 128'd15);
    check("c3_plaintext", b_data_out, Pt);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;

    // Reset in the cycle after round==5, then restart C.1
    a_in_valid = 1'b1;
    a_data_in  = Ct1;
    step();
    a_in_valid = 1'b0;
    n = 0;
    while (a_round != 4'd5 && n < 20) begin
      step();
      n++;
    end
    check("rst_reach_round5", 128'(a_round), 128'd5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_a("midrst");
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    n = 1;
    while (!a_out_valid && n < 40) begin
      step();
      n++;
    end
    check("midrst_latency", 128'(n), 128'd11);
    check("midrst_plaintext", a_data_out, Pt);
    a_out_ready = 1'b1;
    step();

    // Back-to-back blocks with out_ready held high
    a_in_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_in_valid && a_in_ready && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (a_out_valid) check("b2b_plaintext", a_data_out, Pt);
      step();
    end
    a_in_valid = 1'b0;
    check("b2b_accept_count", 128'(nacc), 128'd2);
    if (nacc == 2) check("b2b_accept_spacing", 128'(acc[1] - acc[0]), 128'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
